// File: rtl/demux_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the 1-to-4 stream demultiplexer: select width, lane
// count, beat-counter width and the lane index constants.
// ----------------------------------------------------------------------------
package demux_pkg;

    localparam int SEL_W     = 2;
    localparam int NUM_LANES = 4;
    localparam int CNT_W     = 16;

    localparam logic [SEL_W-1:0] LANE0 = 2'd0;
    localparam logic [SEL_W-1:0] LANE1 = 2'd1;
    localparam logic [SEL_W-1:0] LANE2 = 2'd2;
    localparam logic [SEL_W-1:0] LANE3 = 2'd3;

    // One-hot lane mask for a select value.
    function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [SEL_W-1:0] sel);
        return 4'b0001 << sel;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// ----------------------------------------------------------------------------
// demux_slot
// One-entry register slice for a single output lane. A load writes the entry
// and marks it valid; a drain without a load empties it. Load and drain in
// the same cycle replace the entry with no bubble. The data register is not
// cleared on drain, so an empty lane keeps showing its last payload.
//
// Ports
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   load     : write data_in into the entry this cycle
//   drain    : downstream consumes the entry this cycle
//   data_in  : payload to load
//   valid    : entry holds a beat
//   data     : entry payload
// ----------------------------------------------------------------------------
module demux_slot #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         drain,
    input  logic [N-1:0] data_in,
    output logic         valid,
    output logic [N-1:0] data
);

    logic         valid_q, valid_d;
    logic [N-1:0] data_q, data_d;

    always_comb begin
        valid_d = load | (valid_q & ~drain);
        data_d  = load ? data_in : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/n_bit_1_to_4_stream_demux.sv
// ----------------------------------------------------------------------------
// n_bit_1_to_4_stream_demux
// Routes a valid/ready input stream to one of four output lanes chosen by
// select. Each lane is a one-entry slice (demux_slot), so beats appear one
// cycle after acceptance and lanes drain independently; a stalled lane only
// back-pressures beats addressed to it.
//
// Optional feature: define DEMUX_BEAT_COUNT_EN to add per-lane saturating
// counters of output transfers (cnt0..cnt3) with a synchronous clear cnt_clr.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   select     : destination lane of the current input beat
//   in_valid   : input beat present
//   in_data    : input payload
//   in_ready   : input beat accepted this cycle (if in_valid)
//   out_valid  : per-lane beat present, bit k = lane k
//   y0..y3     : per-lane payload
//   out_ready  : per-lane downstream accept
//   cnt_clr    : (DEMUX_BEAT_COUNT_EN) clear all beat counters
//   cnt0..cnt3 : (DEMUX_BEAT_COUNT_EN) per-lane output transfer counts
// ----------------------------------------------------------------------------
module n_bit_1_to_4_stream_demux
    import demux_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SEL_W-1:0]     select,
    input  logic                 in_valid,
    input  logic [N-1:0]         in_data,
    output logic                 in_ready,
    output logic [NUM_LANES-1:0] out_valid,
    output logic [N-1:0]         y0,
    output logic [N-1:0]         y1,
    output logic [N-1:0]         y2,
    output logic [N-1:0]         y3,
`ifdef DEMUX_BEAT_COUNT_EN
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     cnt0,
    output logic [CNT_W-1:0]     cnt1,
    output logic [CNT_W-1:0]     cnt2,
    output logic [CNT_W-1:0]     cnt3,
`endif
    input  logic [NUM_LANES-1:0] out_ready
);

    logic [NUM_LANES-1:0] lane_valid;
    logic [N-1:0]         lane_data [NUM_LANES];
    logic [NUM_LANES-1:0] lane_load;
    logic                 accept;

    // Ready depends only on the addressed lane, never on in_valid.
    assign in_ready  = !lane_valid[select] || out_ready[select];
    assign accept    = in_valid && in_ready;
    assign lane_load = accept ? lane_onehot(select) : '0;

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        demux_slot #(.N(N)) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (lane_load[k]),
            .drain   (out_ready[k]),
            .data_in (in_data),
            .valid   (lane_valid[k]),
            .data    (lane_data[k])
        );
    end

    assign out_valid = lane_valid;
    assign y0        = lane_data[LANE0];
    assign y1        = lane_data[LANE1];
    assign y2        = lane_data[LANE2];
    assign y3        = lane_data[LANE3];

`ifdef DEMUX_BEAT_COUNT_EN
    logic [CNT_W-1:0] cnt_q [NUM_LANES];
    logic [CNT_W-1:0] cnt_d [NUM_LANES];

    // Clear has priority over a same-cycle transfer; counts stick at all-ones.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            cnt_d[k] = cnt_q[k];
            if (cnt_clr) begin
                cnt_d[k] = '0;
            end else if (lane_valid[k] && out_ready[k] && (cnt_q[k] != '1)) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_LANES; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) cnt_q[k] <= cnt_d[k];
        end
    end

    assign cnt0 = cnt_q[LANE0];
    assign cnt1 = cnt_q[LANE1];
    assign cnt2 = cnt_q[LANE2];
    assign cnt3 = cnt_q[LANE3];
`endif

endmodule

// File: doc/n_bit_1_to_4_stream_demux.md
N_BIT_1_TO_4_STREAM_DEMUX -- requirements
Module: n_bit_1_to_4_stream_demux

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits of the input and of each output lane.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port select  input  2  destination lane (2'b00 = lane 0 … 2'b11 = lane 3) for the current input beat.
REQ-005 SHALL have port in_valid  input  1  input beat present.
REQ-006 SHALL have port in_data  input  N  input beat payload.
REQ-007 SHALL have port in_ready  output  1  block accepts the input beat this cycle.
REQ-008 SHALL have ports out_valid  output  4  per-lane beat present, bit k = lane k.
REQ-009 SHALL have ports y0, y1, y2, y3  output  N each  per-lane payload.
REQ-010 SHALL have port out_ready  input  4  per-lane downstream accept, bit k = lane k.

Function
REQ-011 SHALL transfer an input beat when in_valid && in_ready, and a lane-k beat when out_valid[k] && out_ready[k].
REQ-012 SHALL hold one register entry per lane; an accepted beat is written to lane select only, other lanes unchanged.
REQ-013 SHALL present an accepted beat on yk with out_valid[k]=1 exactly one clk cycle after acceptance (latency 1).
REQ-014 SHALL drive in_ready = !out_valid[select] || out_ready[select], combinationally from select and out_ready (no dependence on in_valid).
REQ-015 SHALL, when lane k is full, out_ready[k]=1 and a new beat targets lane k in the same cycle, drain the old beat and load the new one with out_valid[k] remaining 1 (no bubble).
REQ-016 SHALL keep yk and out_valid[k] stable while out_valid[k]=1 and out_ready[k]=0.
REQ-017 SHALL clear out_valid[k] on a lane-k drain with no simultaneous lane-k load.
REQ-018 SHALL let lanes drain independently; a stalled lane blocks only beats with select addressing it.
REQ-019 SHALL ignore select and in_data when in_valid=0; yk of an empty lane holds its last value.
REQ-020 SHALL never duplicate, drop or reorder beats within a lane.

Reset
REQ-021 SHALL, on rst_n low, immediately clear out_valid to 4'b0000 and y0..y3 to {N{1'b0}}, regardless of clk.
REQ-022 SHALL discard any in-flight beats on reset mid-operation; in_ready reads 1 while in reset.
REQ-023 SHALL resume normal acceptance on the first rising clk edge after rst_n returns high.

Configuration
REQ-024 SHALL, with macro DEMUX_BEAT_COUNT_EN defined, add ports cnt_clr input 1 and cnt0..cnt3 output 16 each: per-lane count of lane output transfers, saturating at 16'hFFFF, synchronously cleared by cnt_clr (clear wins over a simultaneous increment), reset to 0.
REQ-025 SHALL, without DEMUX_BEAT_COUNT_EN, omit those ports and counters entirely; all other behaviour identical.

Structure
REQ-026 SHALL take from shared package demux_pkg: SEL_W=2, NUM_LANES=4, CNT_W=16, and lane index constants LANE0..LANE3.
REQ-027 SHALL implement each lane as sub-module demux_slot (one-entry register slice with load/drain/valid), instantiated four times.

Verification
REQ-028 SHALL cover: N=8, select=2'b10, in_data=8'hA5 one beat, out_ready=4'b1111 -> out_valid=4'b0100, y2=8'hA5 next cycle, cleared the cycle after.
REQ-029 SHALL cover: out_ready[1]=0, two beats 8'h11 then 8'h22 to lane 1 -> first accepted, in_ready=0 for second, y1 holds 8'h11; raise out_ready[1] -> 8'h22 accepted same cycle, y1=8'h22 next cycle, no bubble.
REQ-030 SHALL cover: lane 0 stalled and full, beat 8'h33 to lane 3 -> in_ready=1, y3=8'h33 next cycle, y0 unchanged.
REQ-031 SHALL cover: rst_n pulsed low mid-cycle with lanes 0 and 2 full -> out_valid=4'b0000 and all yk=8'h00 before next clk edge.
REQ-032 SHALL cover, with DEMUX_BEAT_COUNT_EN: 3 lane-1 drains -> cnt1=3, others 0; cnt_clr during a drain -> cnt1=0; preloaded at 16'hFFFF plus a drain -> stays 16'hFFFF.
